mac_seq_ctrl: RTL and testbench

- Initiator-side controller for the fixed-point MAC unit (p <= a*b + c on ce; a/b Q8.8, p/c Q16.16).
- Accepts a stream of KLEN operand pairs (pixel, weight) plus a bias, and steers the MAC through clear, accumulate and drain.
- Feeds the MAC's p back as c so the MAC accumulates, then returns one 32-bit dot-product result over a valid/ready handshake.
- Sits between the window/weight buffers and the activation/pooling stage.

---
 rtl/mac_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_mac_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: initiator-side sequencer for a fixed-point MAC (p <= a*b + c on ce).
// It takes KLEN operand pairs plus a bias, clears the MAC, feeds p back as c to
// accumulate, then returns one dot-product result over a valid/ready handshake.
//
// Ports:
//   clk, sclr           clock (rising edge), asynchronous active-high reset
//   start, bias         begin a dot product (sampled in IDLE), initial accumulator value
//   busy                high whenever the controller is not idle
//   in_valid/in_ready   operand pair handshake, operands in_a (pixel), in_b (weight)
//   res_valid/res_ready result handshake, res_data holds the accumulated result
//   mac_sclr, mac_ce    MAC clear and clock-enable
//   mac_a, mac_b, mac_c MAC operands and addend; mac_p is the MAC output
module mac_seq_ctrl #(
    parameter int unsigned KLEN = 9,
    parameter int unsigned DW   = 16,
    parameter int unsigned AW   = 32
) (
    input  logic          clk,
    input  logic          sclr,
    input  logic          start,
    input  logic [AW-1:0] bias,
    output logic          busy,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [AW-1:0] res_data,
    output logic          mac_sclr,
    output logic          mac_ce,
    output logic [DW-1:0] mac_a,
    output logic [DW-1:0] mac_b,
    output logic [AW-1:0] mac_c,
    input  logic [AW-1:0] mac_p
);

    // Tap counter spans 0..KLEN so the increment on the final accept never wraps.
    localparam int unsigned CW = $clog2(KLEN + 1);
    localparam logic [CW-1:0] LastTap = CW'(KLEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StAcc,
        StDrain,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   tap_q, tap_d;
    logic [AW-1:0]   bias_q, bias_d;
    logic [AW-1:0]   res_q, res_d;
    logic            clr_q, clr_d;
    logic            accept;

    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            state_q <= StIdle;
            tap_q   <= '0;
            bias_q  <= '0;
            res_q   <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            bias_q  <= bias_d;
            res_q   <= res_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        bias_d    = bias_q;
        res_d     = res_q;
        clr_d     = 1'b0;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        accept    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    bias_d  = bias;
                    // Registered so the MAC sees exactly one clear cycle, during CLEAR.
                    clr_d   = 1'b1;
                    state_d = StClear;
                end
            end
            StClear: begin
                tap_d   = '0;
                state_d = StAcc;
            end
            StAcc: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept) begin
                    tap_d = tap_q + CW'(1);
                    if (tap_q == LastTap) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // The MAC registered the last term on the previous edge, so p is final.
                res_d   = mac_p;
                state_d = StDone;
            end
            StDone: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign res_data = res_q;

    // Reset clears the MAC immediately, without waiting for a clock.
    assign mac_sclr = sclr | clr_q;

    // The accept is passed straight through to the MAC; operands are zeroed when idle.
    assign mac_ce = accept;
    assign mac_a  = accept ? in_a : '0;
    assign mac_b  = accept ? in_b : '0;
    // First term adds the bias; later terms feed the running sum back in.
    assign mac_c  = accept ? ((tap_q == '0) ? bias_q : mac_p) : '0;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Testbench for mac_seq_ctrl: a bench MAC closes the loop, a transaction-level
// model predicts every output each cycle, and directed runs pin literal results.
module tb_mac_seq_ctrl;

    localparam int unsigned KLEN = 9;
    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 32;

    logic          clk = 1'b0;
    logic          sclr = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] bias = '0;
    logic          busy;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [AW-1:0] res_data;
    logic          mac_sclr;
    logic          mac_ce;
    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_b;
    logic [AW-1:0] mac_c;
    logic [AW-1:0] mac_p;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_seq_ctrl #(
        .KLEN(KLEN),
        .DW  (DW),
        .AW  (AW)
    ) dut (
        .clk      (clk),
        .sclr     (sclr),
        .start    (start),
        .bias     (bias),
        .busy     (busy),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .mac_sclr (mac_sclr),
        .mac_ce   (mac_ce),
        .mac_a    (mac_a),
        .mac_b    (mac_b),
        .mac_c    (mac_c),
        .mac_p    (mac_p)
    );

    // Q8.8 x Q8.8 gives Q16.16 directly.
    function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = {{16{a[15]}}, a};
        sb = {{16{b[15]}}, b};
        return sa * sb;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bench MAC.
    logic [AW-1:0] p_mac = '0;
    always @(posedge clk or posedge mac_sclr) begin
        if (mac_sclr) p_mac <= '0;
        else if (mac_ce) p_mac <= prod(mac_a, mac_b) + mac_c;
    end
    assign mac_p = p_mac;

    // Transaction-level model: phase of the dot product plus running sum.
    localparam int PhIdle = 0, PhClr = 1, PhAcc = 2, PhDrn = 3, PhDone = 4;
    int            ph    = PhIdle;
    int            terms = 0;
    logic [AW-1:0] sum   = '0;
    logic [AW-1:0] res   = '0;

    always @(posedge clk or posedge sclr) begin
        if (sclr) begin
            ph    <= PhIdle;
            terms <= 0;
            sum   <= '0;
            res   <= '0;
        end else begin
            case (ph)
                PhIdle: if (start) begin
                    sum   <= bias;
                    terms <= 0;
                    ph    <= PhClr;
                end
                PhClr: ph <= PhAcc;
                PhAcc: if (in_valid) begin
                    sum   <= sum + prod(in_a, in_b);
                    terms <= terms + 1;
                    if (terms + 1 == KLEN) ph <= PhDrn;
                end
                PhDrn: begin
                    res <= sum;
                    ph  <= PhDone;
                end
                PhDone: if (res_ready) ph <= PhIdle;
                default: ph <= PhIdle;
            endcase
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    logic          e_ce;
    logic [AW-1:0] first_c = '0;
    always @(negedge clk) begin
        e_ce = (ph == PhAcc) && in_valid;
        chk("busy", {31'b0, busy}, {31'b0, ph != PhIdle});
        chk("in_ready", {31'b0, in_ready}, {31'b0, ph == PhAcc});
        chk("mac_ce", {31'b0, mac_ce}, {31'b0, e_ce});
        chk("mac_a", {16'b0, mac_a}, e_ce ? {16'b0, in_a} : 32'h0);
        chk("mac_b", {16'b0, mac_b}, e_ce ? {16'b0, in_b} : 32'h0);
        chk("mac_c", mac_c, e_ce ? sum : 32'h0);
        chk("res_valid", {31'b0, res_valid}, {31'b0, ph == PhDone});
        chk("res_data", res_data, res);
        chk("mac_sclr", {31'b0, mac_sclr}, {31'b0, sclr || ph == PhClr});
        if (e_ce && terms == 0) first_c = mac_c;
    end

    task automatic do_run(input logic [31:0] bv, input logic [15:0] a, input logic [15:0] b,
                          input bit toggle, input int hold,
                          output logic [31:0] r, output int lat);
        int t0;
        bit got;
        res_ready = (hold == 0);
        @(posedge clk); #1;
        start = 1'b1; bias = bv; in_a = a; in_b = b;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0; in_valid = 1'b1;
        got = 1'b0; lat = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk); #1;
            if (res_valid) begin
                got = 1'b1;
                lat = cyc - t0;
            end else if (toggle) begin
                in_valid = ~in_valid;
            end
        end
        in_valid = 1'b0;
        chk("run_completes", {31'b0, got}, 32'h1);
        r = res_data;
        if (hold == 0) begin
            @(posedge clk); #1;
            chk("res_valid_one_cycle", {31'b0, res_valid}, 32'h0);
            chk("idle_after_handshake", {31'b0, busy}, 32'h0);
        end else begin
            for (int i = 0; i < hold; i++) begin
                start = i[0];
                @(posedge clk); #1;
                chk("hold_res_valid", {31'b0, res_valid}, 32'h1);
                chk("hold_res_data", res_data, r);
            end
            // start together with res_ready: handshake completes, start ignored.
            res_ready = 1'b1; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk("release_busy", {31'b0, busy}, 32'h0);
            chk("release_res_valid", {31'b0, res_valid}, 32'h0);
            @(posedge clk); #1;
            chk("start_ignored_in_done", {31'b0, busy}, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] r;
        int lat;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
        chk("rst_mac_ce", {31'b0, mac_ce}, 32'h0);
        chk("rst_res_valid", {31'b0, res_valid}, 32'h0);
        chk("rst_res_data", res_data, 32'h0);
        chk("rst_mac_sclr", {31'b0, mac_sclr}, 32'h1);
        sclr = 1'b0;
        #1;
        chk("rst_release_mac_sclr", {31'b0, mac_sclr}, 32'h0);

        // Basic run, bias 0: 9 x (1.0 * 2.0).
        do_run(32'h0, 16'h0100, 16'h0200, 1'b0, 0, r, lat);
        chk("run_a_result", r, 32'h0012_0000);
        chk("run_a_latency", lat, 11);

        // With bias 1.0.
        do_run(32'h0001_0000, 16'h0100, 16'h0200, 1'b0, 0, r, lat);
        chk("run_b_result", r, 32'h0013_0000);
        chk("run_b_latency", lat, 11);
        chk("run_b_first_mac_c", first_c, 32'h0001_0000);

        // in_valid toggling every cycle.
        do_run(32'h0, 16'h0100, 16'h0200, 1'b1, 0, r, lat);
        chk("run_c_result", r, 32'h0012_0000);

        // Downstream stall for 5 cycles with start pulses.
        do_run(32'h0000_8000, 16'h0080, 16'h0400, 1'b0, 5, r, lat);
        chk("run_d_result", r, 32'h0012_8000);

        // Abort after the 4th accept.
        @(posedge clk); #1;
        start = 1'b1; bias = 32'h0005_0000; in_a = 16'h0100; in_b = 16'h0300;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_partial_sum", p_mac, 32'h0011_0000);
        sclr = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'h0);
        chk("abort_mac_ce", {31'b0, mac_ce}, 32'h0);
        chk("abort_mac_sclr", {31'b0, mac_sclr}, 32'h1);
        chk("abort_res_data", res_data, 32'h0);
        chk("abort_mac_c", mac_c, 32'h0);
        chk("abort_mac_p_cleared", p_mac, 32'h0);
        @(posedge clk); #1;
        sclr = 1'b0; in_valid = 1'b0;

        // Fresh run after the abort, then back-to-back runs.
        do_run(32'h0, 16'h0100, 16'h0100, 1'b0, 0, r, lat);
        chk("run_e_result", r, 32'h0009_0000);
        do_run(32'h0, 16'h0300, 16'h0100, 1'b0, 0, r, lat);
        chk("run_f_result", r, 32'h001B_0000);
        do_run(32'h0, 16'h0180, 16'hFF00, 1'b0, 0, r, lat);
        chk("run_g_result", r, 32'hFFF2_8000);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
